// File: rtl/reg_file_2r1w_pkg.sv
// Shared widths and register-index constants for the MIPS register file,
// its control unit and its bench.
package reg_file_2r1w_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Datapath-side bundle of the register file: one write port, two operand
// read ports and the board-display debug read port.
interface reg_file_2r1w_if #(
    parameter int DATA_W = reg_file_2r1w_pkg::DATA_W,
    parameter int ADDR_W = reg_file_2r1w_pkg::ADDR_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgReg;
    logic [DATA_W-1:0] DbgData;

    modport master (
        output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, DbgReg,
        input  ReadData1, ReadData2, DbgData
    );

    modport slave (
        input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, DbgReg,
        output ReadData1, ReadData2, DbgData
    );

endinterface

// File: rtl/reg_file_2r1w.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one write
// port, a never-bypassed debug port, r0 hardwired to zero.
module reg_file_2r1w #(
    parameter int DATA_W    = reg_file_2r1w_pkg::DATA_W,
    parameter int ADDR_W    = reg_file_2r1w_pkg::ADDR_W,
    parameter bit WR_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_2r1w_if.slave  bus
);

    import reg_file_2r1w_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] rd_mux [DEPTH];
    logic              wr_active;
    logic              byp1;
    logic              byp2;

    // A write is only live outside reset and never to r0; this gates both
    // the storage enables and the bypass selects.
    assign wr_active = bus.RegWrite && (bus.WriteReg != ADDR_W'(REG_ZERO)) && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign rd_mux[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] entry_reg;
                logic              we;

                assign we = wr_active && (bus.WriteReg == ADDR_W'(gi));

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        entry_reg <= '0;
                    end else if (we) begin
                        entry_reg <= bus.WriteData;
                    end
                end

                assign rd_mux[gi] = entry_reg;
            end
        end
    endgenerate

    assign byp1 = WR_BYPASS && wr_active && (bus.ReadReg1 == bus.WriteReg);
    assign byp2 = WR_BYPASS && wr_active && (bus.ReadReg2 == bus.WriteReg);

    assign bus.ReadData1 = byp1 ? bus.WriteData : rd_mux[bus.ReadReg1];
    assign bus.ReadData2 = byp2 ? bus.WriteData : rd_mux[bus.ReadReg2];
    assign bus.DbgData   = rd_mux[bus.DbgReg];

endmodule
